score_keeper: RTL and testbench

- Match controller downstream of the game logic stage; consumes ball X position and the frame strobe.
- Detects ball exits past either paddle and keeps two-digit BCD scores for player (right paddle) and enemy (left paddle).
- Runs the match FSM (idle, serve delay, play, game over) and drives run_o, which gates ball and paddle updates in the game logic.
- Feeds scores and status to the score overlay renderer.

---
 rtl/score_keeper.sv | 166 ++++++++++++++++
 tb/tb_score_keeper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Match controller: detects ball exits, keeps BCD scores for both sides and sequences
// the idle / serve / play / game-over flow. Every output comes straight from a register.
module score_keeper #(
    parameter int unsigned X_POS_W       = 10,
    parameter int unsigned SCREEN_H_RES  = 640,
    parameter int unsigned SCREEN_BORDER = 10,
    parameter int unsigned WIN_SCORE     = 11,
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned SERVE_CNT_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               new_frame_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic               start_i,
    output logic               run_o,
    output logic [7:0]         player_score_o,
    output logic [7:0]         enemy_score_o,
    output logic               point_o,
    output logic               game_over_o,
    output logic               winner_o
);

    typedef enum logic [1:0] {StIdle, StServe, StPlay, StGameOver} state_e;

    localparam logic [X_POS_W-1:0]     RightLimit = X_POS_W'(SCREEN_H_RES);
    localparam logic [X_POS_W-1:0]     LeftLimit  = X_POS_W'(SCREEN_BORDER);
    localparam logic [SERVE_CNT_W-1:0] ServeLast  = SERVE_CNT_W'(SERVE_FRAMES - 1);
    localparam logic [7:0]             WinBcd     = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    state_e                 state_q, state_d;
    logic [7:0]             player_q, player_d;
    logic [7:0]             enemy_q, enemy_d;
    logic [SERVE_CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic                   out_prev_q, out_prev_d;
    logic                   start_prev_q;
    logic                   winner_q, winner_d;
    logic                   point_q, point_d;
    logic                   run_q, run_d;
    logic                   game_over_q, game_over_d;

    logic       start_rise;
    logic       exit_left;
    logic       exit_right;
    logic       ball_out;
    logic       score_hit;
    logic [7:0] player_inc;
    logic [7:0] enemy_inc;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'h99) begin
            res = 8'h99;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    assign start_rise = start_i & ~start_prev_q;
    assign exit_left  = ball_x_i < LeftLimit;
    assign exit_right = ball_x_i > RightLimit;
    assign ball_out   = exit_left | exit_right;
    // Only the frame on which the ball first leaves counts, so a lingering exit scores once.
    assign score_hit  = new_frame_i & ball_out & ~out_prev_q & (state_q == StPlay);
    assign player_inc = bcd_inc(player_q);
    assign enemy_inc  = bcd_inc(enemy_q);

    always_comb begin
        state_d     = state_q;
        player_d    = player_q;
        enemy_d     = enemy_q;
        serve_cnt_d = serve_cnt_q;
        winner_d    = winner_q;
        point_d     = 1'b0;
        out_prev_d  = new_frame_i ? ball_out : out_prev_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    player_d = 8'h00;
                    enemy_d  = 8'h00;
                    state_d  = StServe;
                end
            end
            StServe: begin
                if (new_frame_i) begin
                    if (serve_cnt_q == ServeLast) begin
                        serve_cnt_d = '0;
                        state_d     = StPlay;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SERVE_CNT_W'(1);
                    end
                end
            end
            StPlay: begin
                if (score_hit) begin
                    point_d = 1'b1;
                    state_d = StServe;
                    if (exit_left) begin
                        player_d = player_inc;
                        if (player_inc == WinBcd) begin
                            state_d  = StGameOver;
                            winner_d = 1'b1;
                        end
                    end else begin
                        enemy_d = enemy_inc;
                        if (enemy_inc == WinBcd) begin
                            state_d  = StGameOver;
                            winner_d = 1'b0;
                        end
                    end
                end
            end
            StGameOver: begin
                if (start_rise) begin
                    player_d = 8'h00;
                    enemy_d  = 8'h00;
                    winner_d = 1'b0;
                    state_d  = StServe;
                end
            end
            default: state_d = StIdle;
        endcase

        run_d       = (state_d == StPlay);
        game_over_d = (state_d == StGameOver);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            player_q     <= 8'h00;
            enemy_q      <= 8'h00;
            serve_cnt_q  <= '0;
            out_prev_q   <= 1'b1;
            start_prev_q <= 1'b1;
            winner_q     <= 1'b0;
            point_q      <= 1'b0;
            run_q        <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_q     <= player_d;
            enemy_q      <= enemy_d;
            serve_cnt_q  <= serve_cnt_d;
            out_prev_q   <= out_prev_d;
            start_prev_q <= start_i;
            winner_q     <= winner_d;
            point_q      <= point_d;
            run_q        <= run_d;
            game_over_q  <= game_over_d;
        end
    end

    assign run_o          = run_q;
    assign player_score_o = player_q;
    assign enemy_score_o  = enemy_q;
    assign point_o        = point_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: reset, serve timing, scoring, exit masking,
// BCD carry, game over, restart and mid-serve reset.
module tb_score_keeper;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       new_frame_i;
    logic [9:0] ball_x_i;
    logic       start_i;
    logic       run_o;
    logic [7:0] player_score_o;
    logic [7:0] enemy_score_o;
    logic       point_o;
    logic       game_over_o;
    logic       winner_o;

    int n_checks = 0;
    int n_pass   = 0;
    int point_cnt = 0;

    score_keeper dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .new_frame_i    (new_frame_i),
        .ball_x_i       (ball_x_i),
        .start_i        (start_i),
        .run_o          (run_o),
        .player_score_o (player_score_o),
        .enemy_score_o  (enemy_score_o),
        .point_o        (point_o),
        .game_over_o    (game_over_o),
        .winner_o       (winner_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (point_o) point_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One frame strobe at the given ball position, then one quiet cycle.
    task automatic frame(input logic [9:0] x);
        ball_x_i    = x;
        new_frame_i = 1'b1;
        @(negedge clk_i);
        new_frame_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic serve_frames(input int n);
        for (int i = 0; i < n; i++) frame(10'd320);
    endtask

    task automatic press();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i       = 1'b0;
        start_i     = 1'b1;
        new_frame_i = 1'b0;
        ball_x_i    = 10'd320;
        repeat (3) @(negedge clk_i);
        check("rst_run", run_o, 0);
        check("rst_player", player_score_o, 8'h00);
        check("rst_enemy", enemy_score_o, 8'h00);
        check("rst_go", game_over_o, 0);
        check("rst_winner", winner_o, 0);
        check("rst_point", point_o, 0);

        // Key held through reset must not start the match.
        rst_i = 1'b1;
        serve_frames(70);
        check("held_key_idle", run_o, 0);

        start_i = 1'b0;
        @(negedge clk_i);
        press();
        serve_frames(59);
        check("serve59_run", run_o, 0);
        serve_frames(1);
        check("serve60_run", run_o, 1);

        frame(10'd5);
        check("left_exit_player", player_score_o, 8'h01);
        check("left_exit_enemy", enemy_score_o, 8'h00);
        check("left_exit_points", point_cnt, 1);
        check("left_exit_run", run_o, 0);
        serve_frames(59);
        check("reserve59_run", run_o, 0);
        serve_frames(1);
        check("reserve60_run", run_o, 1);

        press();
        check("start_in_play_run", run_o, 1);
        frame(10'd320);
        check("start_in_play_go", game_over_o, 0);

        // Persistent right exit: scores once, and is still masked on re-entry to play.
        repeat (5) frame(10'd700);
        check("hold_enemy", enemy_score_o, 8'h01);
        check("hold_points", point_cnt, 2);
        repeat (55) frame(10'd700);
        check("hold_serve_run", run_o, 0);
        frame(10'd700);
        check("hold_play_run", run_o, 1);
        frame(10'd700);
        check("masked_enemy", enemy_score_o, 8'h01);
        check("masked_points", point_cnt, 2);
        check("masked_run", run_o, 1);
        frame(10'd320);

        for (int i = 0; i < 8; i++) begin
            frame(10'd5);
            serve_frames(60);
        end
        check("player_nine", player_score_o, 8'h09);
        frame(10'd5);
        check("player_ten", player_score_o, 8'h10);
        serve_frames(60);

        frame(10'd640);
        check("edge640_enemy", enemy_score_o, 8'h01);
        frame(10'd10);
        check("edge10_player", player_score_o, 8'h10);
        check("edges_points", point_cnt, 11);
        frame(10'd641);
        check("edge641_enemy", enemy_score_o, 8'h02);
        serve_frames(60);

        frame(10'd9);
        check("win_player", player_score_o, 8'h11);
        check("win_go", game_over_o, 1);
        check("win_winner", winner_o, 1);
        check("win_run", run_o, 0);
        check("win_points", point_cnt, 13);

        frame(10'd320);
        frame(10'd5);
        frame(10'd320);
        check("go_hold_player", player_score_o, 8'h11);
        check("go_hold_go", game_over_o, 1);
        check("go_hold_points", point_cnt, 13);

        press();
        check("restart_player", player_score_o, 8'h00);
        check("restart_enemy", enemy_score_o, 8'h00);
        check("restart_winner", winner_o, 0);
        check("restart_go", game_over_o, 0);
        check("restart_run", run_o, 0);
        serve_frames(60);
        check("restart_play", run_o, 1);

        frame(10'd5);
        serve_frames(30);
        check("pre_rst_player", player_score_o, 8'h01);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_player", player_score_o, 8'h00);
        check("midrst_run", run_o, 0);
        check("midrst_go", game_over_o, 0);
        rst_i = 1'b1;
        serve_frames(70);
        check("after_rst_idle", run_o, 0);
        press();
        serve_frames(60);
        check("after_rst_play", run_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
